// File: rtl/display_capture.sv
// Captures a multiplexed 4-digit 7-segment scan into whole frames (optional BLINK_DETECT_EN adds per-digit blink flags).
// Latency: a slot is accepted after SETTLE stable cycles; outputs/pulses register one cycle after the accepting cycle. No backpressure.
module display_capture #(
    parameter int SETTLE       = 2,
    parameter int BLINK_WINDOW = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] anode,
    input  logic [6:0] cathode,
    output logic [3:0] digit_mt,
    output logic [3:0] digit_mo,
    output logic [3:0] digit_st,
    output logic [3:0] digit_so,
    output logic [3:0] blank,
    output logic [3:0] blink,
    output logic       frame_valid,
    output logic       seq_err,
    output logic       seg_err
);

    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
        $error("SETTLE out of range");
    end
    if (BLINK_WINDOW < 2 || BLINK_WINDOW > 15) begin : g_bad_window
        $error("BLINK_WINDOW out of range");
    end

    localparam logic [4:0] SETTLE_W = 5'(SETTLE);

    typedef enum logic [2:0] {HUNT, S0, S1, S2, S3} state_t;
    state_t state_q, state_d;

    logic [10:0] pair_q;
    logic [4:0]  cnt_q, held;
    logic        is_idle, is_legal, accept, illegal_evt;
    logic [1:0]  pos;
    logic        cur_blank, cur_bad;
    logic [3:0]  cur_dig;
    logic        stage_en, pub, seq_evt;
    logic [3:0]  stg_dig [3];
    logic [2:0]  stg_blank, stg_bad;
    logic [3:0]  nxt_mt, nxt_mo, nxt_st, nxt_so, nxt_blank;
    logic        nxt_bad;

    // held counts how many cycles the current pair has been seen, including this one
    always_comb begin
        is_idle  = (anode == 4'b1111);
        is_legal = 1'b1;
        pos      = 2'd0;
        case (anode)
            4'b0111: pos = 2'd0;
            4'b1011: pos = 2'd1;
            4'b1101: pos = 2'd2;
            4'b1110: pos = 2'd3;
            default: is_legal = 1'b0;
        endcase
        held        = ({anode, cathode} == pair_q) ? cnt_q + 5'd1 : 5'd1;
        accept      = is_legal && (held == SETTLE_W);
        illegal_evt = !is_idle && !is_legal && (held == 5'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_q <= '1;
            cnt_q  <= '0;
        end else begin
            pair_q <= {anode, cathode};
            if (is_idle)
                cnt_q <= '0;
            else if (held > SETTLE_W)
                cnt_q <= SETTLE_W;
            else
                cnt_q <= held;
        end
    end

    always_comb begin
        cur_blank = (cathode == 7'b1111111);
        cur_bad   = 1'b0;
        cur_dig   = 4'h0;
        case (cathode)
            7'b1000000: cur_dig = 4'd0;
            7'b1111001: cur_dig = 4'd1;
            7'b0100100: cur_dig = 4'd2;
            7'b0110000: cur_dig = 4'd3;
            7'b0011001: cur_dig = 4'd4;
            7'b0010010: cur_dig = 4'd5;
            7'b0000010: cur_dig = 4'd6;
            7'b1111000: cur_dig = 4'd7;
            7'b0000000: cur_dig = 4'd8;
            7'b0010000: cur_dig = 4'd9;
            7'b1111111: cur_dig = 4'd0;
            default: begin
                cur_dig = 4'hF;
                cur_bad = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= HUNT;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        stage_en = 1'b0;
        pub      = 1'b0;
        seq_evt  = 1'b0;
        if (illegal_evt) begin
            seq_evt = 1'b1;
            state_d = HUNT;
        end else if (accept) begin
            if (state_q == HUNT || state_q == S0) begin
                if (pos == 2'd0) begin
                    state_d  = S1;
                    stage_en = 1'b1;
                end
            end else if ((state_q == S1 && pos == 2'd1) || (state_q == S2 && pos == 2'd2)) begin
                state_d  = (state_q == S1) ? S2 : S3;
                stage_en = 1'b1;
            end else if (state_q == S3 && pos == 2'd3) begin
                state_d = S0;
                pub     = 1'b1;
            end else begin
                // out-of-order slot: an mt slot can still start a fresh frame
                seq_evt  = 1'b1;
                state_d  = (pos == 2'd0) ? S1 : HUNT;
                stage_en = (pos == 2'd0);
            end
        end
    end

    always_comb begin
        nxt_blank = {stg_blank[0], stg_blank[1], stg_blank[2], cur_blank};
        nxt_mt    = stg_blank[0] ? digit_mt : stg_dig[0];
        nxt_mo    = stg_blank[1] ? digit_mo : stg_dig[1];
        nxt_st    = stg_blank[2] ? digit_st : stg_dig[2];
        nxt_so    = cur_blank    ? digit_so : cur_dig;
        nxt_bad   = (|stg_bad) | cur_bad;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) stg_dig[i] <= '0;
            stg_blank <= '0;
            stg_bad   <= '0;
        end else if (stage_en) begin
            case (pos)
                2'd0: begin stg_dig[0] <= cur_dig; stg_blank[0] <= cur_blank; stg_bad[0] <= cur_bad; end
                2'd1: begin stg_dig[1] <= cur_dig; stg_blank[1] <= cur_blank; stg_bad[1] <= cur_bad; end
                2'd2: begin stg_dig[2] <= cur_dig; stg_blank[2] <= cur_blank; stg_bad[2] <= cur_bad; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_mt    <= '0;
            digit_mo    <= '0;
            digit_st    <= '0;
            digit_so    <= '0;
            blank       <= '0;
            frame_valid <= 1'b0;
            seq_err     <= 1'b0;
            seg_err     <= 1'b0;
        end else begin
            frame_valid <= pub;
            seq_err     <= seq_evt;
            seg_err     <= pub & nxt_bad;
            if (pub) begin
                digit_mt <= nxt_mt;
                digit_mo <= nxt_mo;
                digit_st <= nxt_st;
                digit_so <= nxt_so;
                blank    <= nxt_blank;
            end
        end
    end

`ifdef BLINK_DETECT_EN
    logic [3:0] bcnt [4];

    // counters start saturated so nothing blinks until a blank toggle is seen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) bcnt[i] <= 4'hF;
        end else if (pub) begin
            for (int i = 0; i < 4; i++) begin
                if (nxt_blank[i] != blank[i])
                    bcnt[i] <= 4'h0;
                else if (bcnt[i] != 4'hF)
                    bcnt[i] <= bcnt[i] + 4'h1;
            end
        end
    end

    always_comb begin
        blink = '0;
        for (int i = 0; i < 4; i++) blink[i] = (bcnt[i] < 4'(BLINK_WINDOW));
    end
`else
    assign blink = 4'b0000;
`endif

endmodule

// File: tb/tb_display_capture.sv
// Bench for display_capture: constant frame table, hand-written corner sequences, and randomized slots against a slot-level model.
module tb_display_capture;
    localparam int SETTLE = 2;
    localparam int BW     = 8;
    localparam logic [6:0] SEG_TAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    localparam logic [6:0] BLK = 7'b1111111;
    localparam logic [6:0] BAD = 7'b0101010;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] anode = 4'hF;
    logic [6:0] cathode = 7'h7F;
    logic [3:0] digit_mt, digit_mo, digit_st, digit_so, blank, blink;
    logic       frame_valid, seq_err, seg_err;

    always #5 clk = ~clk;

    display_capture #(.SETTLE(SETTLE), .BLINK_WINDOW(BW)) dut (
        .clk(clk), .rst(rst), .anode(anode), .cathode(cathode),
        .digit_mt(digit_mt), .digit_mo(digit_mo), .digit_st(digit_st), .digit_so(digit_so),
        .blank(blank), .blink(blink), .frame_valid(frame_valid), .seq_err(seq_err), .seg_err(seg_err)
    );

    int checks = 0;
    int failures = 0;
    int tot_fv = 0, tot_seq = 0, tot_seg = 0;
    logic [10:0] prev_pair = '1;

    // slot-level model: scan position expected next (0 = hunting), queue of cathodes for the frame
    int          m_exp;
    logic [6:0]  m_q[$];
    int          m_dig [4];
    bit          m_blank [4];
    int          m_bcnt [4];
    int          e_fv, e_seq, e_seg;

    typedef struct {
        logic [3:0][6:0] c;
        logic [15:0]     dig;
        logic [3:0]      blk;
        int              seg;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int seg_value(input logic [6:0] c);
        if (c == BLK) return 16;
        for (int d = 0; d < 10; d++) if (SEG_TAB[d] == c) return d;
        return 15;
    endfunction

    function automatic bit is_legal(input logic [3:0] a);
        return a == 4'b0111 || a == 4'b1011 || a == 4'b1101 || a == 4'b1110;
    endfunction

    function automatic logic [3:0] exp_blink();
        logic [3:0] b = '0;
`ifdef BLINK_DETECT_EN
        for (int p = 0; p < 4; p++) b[3-p] = (m_bcnt[p] < BW);
`endif
        return b;
    endfunction

    task automatic model_reset();
        m_exp = 0;
        m_q.delete();
        for (int p = 0; p < 4; p++) begin
            m_dig[p] = 0; m_blank[p] = 1'b0; m_bcnt[p] = 15;
        end
    endtask

    task automatic model_publish();
        for (int p = 0; p < 4; p++) begin
            int v = seg_value(m_q[p]);
            bit nb = (v == 16);
            if (nb != m_blank[p]) m_bcnt[p] = 0;
            else if (m_bcnt[p] < 15) m_bcnt[p]++;
            m_blank[p] = nb;
            if (!nb) m_dig[p] = v;
            if (v == 15) e_seg = 1;
        end
        e_fv = 1;
        m_q.delete();
    endtask

    task automatic model_slot(input int p, input logic [6:0] c);
        if (m_exp == 0) begin
            if (p == 0) begin m_q.push_back(c); m_exp = 1; end
        end else if (p == m_exp) begin
            m_q.push_back(c);
            m_exp++;
            if (m_exp == 4) begin model_publish(); m_exp = 0; end
        end else begin
            e_seq = 1;
            m_q.delete();
            m_exp = 0;
            if (p == 0) begin m_q.push_back(c); m_exp = 1; end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_digits"}, 32'({digit_mt, digit_mo, digit_st, digit_so}),
            32'({4'(m_dig[0]), 4'(m_dig[1]), 4'(m_dig[2]), 4'(m_dig[3])}));
        chk({tag, "_blank"}, 32'(blank), 32'({m_blank[0], m_blank[1], m_blank[2], m_blank[3]}));
        chk({tag, "_blink"}, 32'(blink), 32'(exp_blink()));
    endtask

    // Drive one pair for `hold` cycles (entered just after a falling edge), count pulses, then compare to the model.
    task automatic apply(input logic [3:0] a, input logic [6:0] c, input int hold);
        int a_fv = 0, a_seq = 0, a_seg = 0, p = 0;
        e_fv = 0; e_seq = 0; e_seg = 0;
        for (int i = 0; i < 4; i++) if (a == ~(4'b1000 >> i)) p = i;
        if (is_legal(a) && hold >= SETTLE) model_slot(p, c);
        else if (!is_legal(a) && a != 4'hF) begin
            e_seq = 1; m_exp = 0; m_q.delete();
        end
        anode = a; cathode = c; prev_pair = {a, c};
        repeat (hold) begin
            @(negedge clk);
            a_fv += int'(frame_valid); a_seq += int'(seq_err); a_seg += int'(seg_err);
        end
        #1;
        tot_fv += a_fv; tot_seq += a_seq; tot_seg += a_seg;
        chk("fv_pulses", 32'(a_fv), 32'(e_fv));
        chk("seq_pulses", 32'(a_seq), 32'(e_seq));
        chk("seg_pulses", 32'(a_seg), 32'(e_seg));
        check_outputs("slot");
    endtask

    task automatic scan(input logic [6:0] c3, input logic [6:0] c2, input logic [6:0] c1, input logic [6:0] c0);
        apply(4'b0111, c3, SETTLE + 1);
        apply(4'b1011, c2, SETTLE + 1);
        apply(4'b1101, c1, SETTLE + 1);
        apply(4'b1110, c0, SETTLE + 1);
    endtask

    task automatic do_reset();
        anode = 4'hF; cathode = BLK;
        rst = 1'b1;
        #1;
        chk("rst_outputs", 32'({digit_mt, digit_mo, digit_st, digit_so, blank, blink, frame_valid, seq_err, seg_err}), 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        prev_pair = {4'hF, BLK};
    endtask

    initial begin
        int fv0, seq0, seg0;
        logic [15:0] saved;

        vecs[0] = '{c: {SEG_TAB[0], SEG_TAB[2], SEG_TAB[3], SEG_TAB[1]}, dig: 16'h0231, blk: 4'b0000, seg: 0};
        vecs[1] = '{c: {SEG_TAB[9], SEG_TAB[5], SEG_TAB[7], SEG_TAB[8]}, dig: 16'h9578, blk: 4'b0000, seg: 0};
        vecs[2] = '{c: {SEG_TAB[4], BLK, SEG_TAB[6], SEG_TAB[2]},        dig: 16'h4562, blk: 4'b0100, seg: 0};
        vecs[3] = '{c: {SEG_TAB[1], SEG_TAB[3], SEG_TAB[0], BAD},        dig: 16'h130F, blk: 4'b0000, seg: 1};
        vecs[4] = '{c: {BLK, BLK, BLK, BLK},                             dig: 16'h130F, blk: 4'b1111, seg: 0};
        vecs[5] = '{c: {BAD, SEG_TAB[8], BLK, SEG_TAB[7]},               dig: 16'hF807, blk: 4'b0010, seg: 1};

        do_reset();

        for (int i = 0; i < 6; i++) begin
            fv0 = tot_fv; seg0 = tot_seg;
            scan(vecs[i].c[3], vecs[i].c[2], vecs[i].c[1], vecs[i].c[0]);
            chk("tbl_digits", 32'({digit_mt, digit_mo, digit_st, digit_so}), 32'(vecs[i].dig));
            chk("tbl_blank", 32'(blank), 32'(vecs[i].blk));
            chk("tbl_fv", 32'(tot_fv - fv0), 32'd1);
            chk("tbl_seg", 32'(tot_seg - seg0), 32'(vecs[i].seg));
        end

        // out-of-order slot aborts the frame without touching outputs
        saved = {digit_mt, digit_mo, digit_st, digit_so};
        fv0 = tot_fv; seq0 = tot_seq;
        apply(4'b0111, SEG_TAB[4], SETTLE + 1);
        apply(4'b1101, SEG_TAB[2], SETTLE + 1);
        chk("order_seq", 32'(tot_seq - seq0), 32'd1);
        chk("order_fv", 32'(tot_fv - fv0), 32'd0);
        chk("order_hold", 32'({digit_mt, digit_mo, digit_st, digit_so}), 32'(saved));
        scan(SEG_TAB[1], SEG_TAB[2], SEG_TAB[3], SEG_TAB[4]);
        chk("order_recover", 32'({digit_mt, digit_mo, digit_st, digit_so}), 32'h1234);

        // reset in the middle of a frame drops the staged slots
        apply(4'b0111, SEG_TAB[5], SETTLE + 1);
        apply(4'b1011, SEG_TAB[6], SETTLE + 1);
        do_reset();
        fv0 = tot_fv;
        apply(4'b1101, SEG_TAB[7], SETTLE + 1);
        apply(4'b1110, SEG_TAB[8], SETTLE + 1);
        chk("rst_no_frame", 32'(tot_fv - fv0), 32'd0);
        scan(SEG_TAB[5], SEG_TAB[6], SEG_TAB[7], SEG_TAB[8]);
        chk("rst_next_frame", 32'(tot_fv - fv0), 32'd1);
        chk("rst_next_digits", 32'({digit_mt, digit_mo, digit_st, digit_so}), 32'h5678);

`ifdef BLINK_DETECT_EN
        do_reset();
        for (int f = 0; f < 10; f++)
            scan((f % 2 == 1) ? SEG_TAB[0] : BLK, SEG_TAB[1], SEG_TAB[2], SEG_TAB[3]);
        chk("blink_alt", 32'(blink), 32'b1000);
        for (int f = 0; f < 7; f++) scan(SEG_TAB[0], SEG_TAB[1], SEG_TAB[2], SEG_TAB[3]);
        chk("blink_7steady", 32'(blink), 32'b1000);
        scan(SEG_TAB[0], SEG_TAB[1], SEG_TAB[2], SEG_TAB[3]);
        chk("blink_8steady", 32'(blink), 32'b0000);
`endif

        begin
            int nextp = 0;
            for (int it = 0; it < 400; it++) begin
                int r = int'($urandom_range(0, 99));
                int hold, p;
                logic [3:0] a;
                logic [6:0] c;
                if (r < 8) begin
                    a = 4'hF; c = 7'($urandom); hold = int'($urandom_range(1, 3));
                end else if (r < 16) begin
                    do a = 4'($urandom); while (a == 4'hF || is_legal(a));
                    c = 7'($urandom); hold = int'($urandom_range(1, 3));
                end else begin
                    p = ($urandom_range(0, 9) < 7) ? nextp : int'($urandom_range(0, 3));
                    nextp = (p + 1) % 4;
                    a = ~(4'b1000 >> p);
                    r = int'($urandom_range(0, 99));
                    if (r < 75) c = SEG_TAB[$urandom_range(0, 9)];
                    else if (r < 87) c = BLK;
                    else begin
                        c = 7'($urandom);
                        if (seg_value(c) != 15) c = BAD;
                    end
                    if (SETTLE > 1 && $urandom_range(0, 9) == 0) hold = int'($urandom_range(1, SETTLE - 1));
                    else hold = int'($urandom_range(SETTLE, SETTLE + 2));
                end
                if (a != 4'hF && {a, c} == prev_pair) apply(4'hF, BLK, 1);
                apply(a, c, hold);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/display_capture.md
DISPLAY_CAPTURE -- requirements
Module: display_capture

Interface
REQ-001 SHALL have parameter SETTLE, default 2, meaning consecutive clk cycles an anode/cathode pair must hold unchanged before the slot is accepted (legal range 1..15).
REQ-002 SHALL have parameter BLINK_WINDOW, default 8, meaning the number of frames after a blank/non-blank toggle during which a digit is reported blinking (legal range 2..15).
REQ-003 SHALL have port clk, input, 1 bit, meaning the single capture clock, with all state updated on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning reset: asynchronous, active-high.
REQ-005 SHALL have port anode, input, 4 bits, meaning multiplexed digit select, active-low, with bit3 = minutes tens and bit0 = seconds ones.
REQ-006 SHALL have port cathode, input, 7 bits, meaning segments gfedcba, active-low.
REQ-007 SHALL have ports digit_mt, digit_mo, digit_st and digit_so, outputs, 4 bits each, meaning the decoded minutes tens, minutes ones, seconds tens and seconds ones.
REQ-008 SHALL have port blank, output, 4 bits, meaning the per-digit blank flags, bit3 = mt.
REQ-009 SHALL have port blink, output, 4 bits, meaning the per-digit blinking flags, bit3 = mt.
REQ-010 SHALL have port frame_valid, output, 1 bit, meaning a one-cycle pulse when a complete frame has been published.
REQ-011 SHALL have port seq_err, output, 1 bit, meaning a one-cycle pulse on a scan-order violation.
REQ-012 SHALL have port seg_err, output, 1 bit, meaning a one-cycle pulse on an undecodable cathode pattern.

Function
REQ-013 SHALL sample anode and cathode directly, since both are synchronous to clk.
REQ-014 SHALL accept a slot when the anode is one of 0111/1011/1101/1110 and the anode/cathode pair has been unchanged for SETTLE cycles; each slot SHALL be accepted exactly once per stable period.
REQ-015 SHALL restart the settle count on any change of the anode/cathode pair.
REQ-016 SHALL treat anode 1111 as idle: ignored, settle count cleared, scan state unchanged.
REQ-017 SHALL treat any other anode pattern (zero or multiple lows) as illegal: seq_err pulses the next cycle and the FSM returns to HUNT.
REQ-018 SHALL implement FSM states HUNT, S0, S1, S2 and S3.
REQ-019 In HUNT the FSM SHALL wait for an accepted slot 0111 and then move to S1 with the mt slot staged.
REQ-020 In S1, S2 and S3 the FSM SHALL expect slots 1011, 1101 and 1110 respectively.
REQ-021 An accepted slot out of expected order SHALL pulse seq_err, discard the staged data, and move to S1 if the offending slot is 0111, otherwise to HUNT.
REQ-022 Acceptance of slot 1110 in S3 SHALL publish all four staged digits and the blank flags in the same cycle, pulse frame_valid in that cycle, and move to S0; S0 SHALL behave as HUNT, so back-to-back frames are supported.
REQ-023 Decode SHALL be: 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9.
REQ-024 Cathode 1111111 SHALL set the digit's blank bit and leave the digit field at its last published value.
REQ-025 Any other cathode pattern SHALL stage 4'hF with blank=0 and pulse seg_err when the frame publishes; seg_err SHALL NOT pulse if the frame is aborted.
REQ-026 Outputs SHALL change only at frame publish, and SHALL never show a partial frame.
REQ-027 seq_err and a frame publish SHALL be mutually exclusive in any cycle.

Reset
REQ-028 rst SHALL force asynchronously: FSM to HUNT, settle counter to 0, staging registers to 0, and all digit fields 0.
REQ-029 rst SHALL force blank=0000, blink=0000 and frame_valid, seq_err, seg_err to 0.
REQ-030 rst SHALL set the blink counters to saturated, so no digit is reported blinking.
REQ-031 rst asserted mid-frame SHALL drop staged data, and no frame_valid SHALL follow the release of reset.

Configuration
REQ-032 With BLINK_DETECT_EN defined, each digit SHALL keep a 4-bit saturating frame counter, cleared at a publish where that digit's blank bit differs from its previously published blank bit, and incremented at every other publish.
REQ-033 With BLINK_DETECT_EN defined, blink[i] SHALL be 1 while counter[i] < BLINK_WINDOW.
REQ-034 Without BLINK_DETECT_EN, blink SHALL be constant 0000 and no blink counter logic SHALL be present.

Verification
REQ-035 Verification SHALL cover: SETTLE=2, scan 0111/1000000, 1011/0100100, 1101/0110000, 1110/1111001, each held 3 cycles -> one frame_valid; digits 0,2,3,1; blank 0000.
REQ-036 Verification SHALL cover: slots 0111 then 1101 -> seq_err pulse, no frame_valid, outputs unchanged, next full scan publishes normally.
REQ-037 Verification SHALL cover: slot 1011 cathode 1111111 in a frame after 1011 showed 5 -> digit_mo stays 5, blank=0100.
REQ-038 Verification SHALL cover: slot 1110 cathode 0101010 -> digit_so=F, seg_err pulses with frame_valid.
REQ-039 Verification SHALL cover, with BLINK_DETECT_EN defined: mt alternating blank/0 every frame -> blink=1000 held; mt steady for 8 frames -> blink=0000.
REQ-040 Verification SHALL cover: rst asserted after slot 1011 is accepted -> outputs immediately at reset values, and no frame_valid until the next complete 4-slot scan.
